// File: rtl/pe_operand_feeder.sv
// Drives one PE through clear, weight load, activation stream and drain from host-written buffers.
// Latency: clear at T+1 after start; backpressure: activation valid/data held until upstream_ready.
module pe_operand_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int WBUF_DEPTH   = 16,
  parameter int ABUF_DEPTH   = 16,
  parameter int DRAIN_CYCLES = 6,
  localparam int MAX_DEPTH   = (WBUF_DEPTH > ABUF_DEPTH) ? WBUF_DEPTH : ABUF_DEPTH,
  localparam int ADDR_W      = $clog2(MAX_DEPTH),
  localparam int WDAT_W      = (DATA_WIDTH > WEIGHT_WIDTH) ? DATA_WIDTH : WEIGHT_WIDTH,
  localparam int NW_W        = $clog2(WBUF_DEPTH) + 1,
  localparam int NA_W        = $clog2(ABUF_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic                           wr_sel,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [WDAT_W-1:0]              wr_data,
  input  logic [NW_W-1:0]                num_weights,
  input  logic [NA_W-1:0]                num_acts,
  input  logic [1:0]                     cfg_act_func,
  input  logic [1:0]                     cfg_dataflow,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [NA_W-1:0]                acts_sent,
  output logic                           pe_enable,
  output logic [1:0]                     pe_act_func_sel,
  output logic [1:0]                     pe_dataflow_mode,
  output logic                           pe_clear_acc,
  output logic                           pe_load_weight,
  output logic signed [WEIGHT_WIDTH-1:0] pe_weight_in,
  output logic signed [DATA_WIDTH-1:0]   pe_activation_in,
  output logic                           pe_upstream_valid,
  input  logic                           pe_upstream_ready
);

  localparam int WI_W  = $clog2(WBUF_DEPTH);
  localparam int AI_W  = $clog2(ABUF_DEPTH);
  localparam int DC_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);
  localparam logic [NW_W-1:0] NW_MAX  = NW_W'(WBUF_DEPTH);
  localparam logic [NW_W-1:0] NW_ONE  = NW_W'(1);
  localparam logic [NA_W-1:0] NA_MAX  = NA_W'(ABUF_DEPTH);
  localparam logic [NA_W-1:0] NA_ONE  = NA_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOADW,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [WEIGHT_WIDTH-1:0] wbuf [WBUF_DEPTH];
  logic signed [DATA_WIDTH-1:0]   abuf [ABUF_DEPTH];

  logic [NW_W-1:0]                nw_q;
  logic [NA_W-1:0]                na_q;
  logic [NW_W-1:0]                widx_q;
  logic [NA_W-1:0]                sent_q;
  logic [DC_W-1:0]                dcnt_q;
  logic [1:0]                     func_q;
  logic [1:0]                     mode_q;
  logic signed [WEIGHT_WIDTH-1:0] wt_q;
  logic signed [DATA_WIDTH-1:0]   act_q;

  logic            idle_start;
  logic            wr_ok;
  logic [NA_W-1:0] sent_inc;
  logic [NW_W-1:0] nw_clamp;
  logic [NA_W-1:0] na_clamp;

  assign idle_start = (state_q == S_IDLE) && start;
  // Writes are only honoured while idle, and never alongside an accepted start.
  assign wr_ok      = wr_en && (state_q == S_IDLE) && !start;
  assign sent_inc   = sent_q + NA_ONE;
  assign nw_clamp   = (num_weights > NW_MAX) ? NW_MAX : num_weights;
  assign na_clamp   = (num_acts > NA_MAX) ? NA_MAX : num_acts;

  always_ff @(posedge clk) begin
    if (wr_ok && !wr_sel && (int'(wr_addr) < WBUF_DEPTH)) begin
      wbuf[wr_addr[WI_W-1:0]] <= wr_data[WEIGHT_WIDTH-1:0];
    end
    if (wr_ok && wr_sel && (int'(wr_addr) < ABUF_DEPTH)) begin
      abuf[wr_addr[AI_W-1:0]] <= wr_data[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (nw_q != '0)      state_d = S_LOADW;
        else if (na_q != '0) state_d = S_STREAM;
        else                 state_d = S_DRAIN;
      end
      S_LOADW: begin
        // widx_q counts weights already presented, so equality marks the last one.
        if (widx_q == nw_q) state_d = (na_q != '0) ? S_STREAM : S_DRAIN;
      end
      S_STREAM: begin
        if (pe_upstream_ready && (sent_inc == na_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (dcnt_q == DC_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nw_q   <= '0;
      na_q   <= '0;
      widx_q <= '0;
      sent_q <= '0;
      dcnt_q <= '0;
      func_q <= '0;
      mode_q <= '0;
      wt_q   <= '0;
      act_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (idle_start) begin
            nw_q   <= nw_clamp;
            na_q   <= na_clamp;
            func_q <= cfg_act_func;
            mode_q <= cfg_dataflow;
            sent_q <= '0;
          end
        end
        S_CLEAR: begin
          widx_q <= NW_ONE;
          dcnt_q <= '0;
          if (nw_q != '0)      wt_q  <= wbuf[0];
          else if (na_q != '0) act_q <= abuf[0];
        end
        S_LOADW: begin
          if (widx_q != nw_q) begin
            wt_q   <= wbuf[widx_q[WI_W-1:0]];
            widx_q <= widx_q + NW_ONE;
          end else if (na_q != '0) begin
            act_q <= abuf[0];
          end
        end
        S_STREAM: begin
          if (pe_upstream_ready) begin
            sent_q <= sent_inc;
            if (sent_inc != na_q) act_q <= abuf[sent_inc[AI_W-1:0]];
          end
        end
        S_DRAIN: begin
          dcnt_q <= dcnt_q + DC_ONE;
        end
        default: ;
      endcase
    end
  end

  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign pe_enable         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign pe_clear_acc      = (state_q == S_CLEAR);
  assign pe_load_weight    = (state_q == S_LOADW);
  assign pe_upstream_valid = (state_q == S_STREAM);
  assign acts_sent         = sent_q;
  assign pe_act_func_sel   = func_q;
  assign pe_dataflow_mode  = mode_q;
  assign pe_weight_in      = wt_q;
  assign pe_activation_in  = act_q;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Randomized bench for pe_operand_feeder against a cycle-timeline reference model.
module tb_pe_operand_feeder;

  localparam int DRAIN = 6;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en, wr_sel;
  logic [3:0]        wr_addr;
  logic [7:0]        wr_data;
  logic [4:0]        num_weights, num_acts;
  logic [1:0]        cfg_act_func, cfg_dataflow;
  logic              start;
  logic              busy, done;
  logic [4:0]        acts_sent;
  logic              pe_enable;
  logic [1:0]        pe_act_func_sel, pe_dataflow_mode;
  logic              pe_clear_acc, pe_load_weight;
  logic signed [7:0] pe_weight_in, pe_activation_in;
  logic              pe_upstream_valid, pe_upstream_ready;

  pe_operand_feeder dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_weights(num_weights), .num_acts(num_acts), .cfg_act_func(cfg_act_func),
    .cfg_dataflow(cfg_dataflow), .start(start), .busy(busy), .done(done), .acts_sent(acts_sent),
    .pe_enable(pe_enable), .pe_act_func_sel(pe_act_func_sel), .pe_dataflow_mode(pe_dataflow_mode),
    .pe_clear_acc(pe_clear_acc), .pe_load_weight(pe_load_weight), .pe_weight_in(pe_weight_in),
    .pe_activation_in(pe_activation_in), .pe_upstream_valid(pe_upstream_valid),
    .pe_upstream_ready(pe_upstream_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] wmodel [DEPTH];
  logic [7:0] amodel [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic host_wr(input logic sel, input int addr, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr[3:0]; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) amodel[addr] = d;
    else     wmodel[addr] = d;
  endtask

  // mode: 0 ready always high, 1 random ready, 2 four-cycle stall on activation index 1.
  task automatic run(input int nw, input int na, input logic [1:0] af, input logic [1:0] df,
                     input int mode, input int poke_r, input int abort_r);
    int  nwc, nac, sent, end_r, done_r, stall;
    bit  in_stream, rdy, finished;
    nwc = (nw > DEPTH) ? DEPTH : nw;
    nac = (na > DEPTH) ? DEPTH : na;
    sent = 0; stall = 4; finished = 0;
    end_r = (nac == 0) ? 1 + nwc : -1;
    @(negedge clk);
    num_weights = nw[4:0]; num_acts = na[4:0];
    cfg_act_func = af; cfg_dataflow = df; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble the config inputs to show they were latched at start.
    cfg_act_func = ~af; cfg_dataflow = ~df; num_weights = 5'd0; num_acts = 5'd0;
    for (int r = 1; r < 300; r++) begin
      done_r = (end_r >= 0) ? end_r + DRAIN + 1 : 100000;
      in_stream = (r >= 2 + nwc) && (sent < nac);
      check("clear_acc", {31'h0, pe_clear_acc}, {31'h0, r == 1});
      check("load_weight", {31'h0, pe_load_weight}, {31'h0, (r >= 2) && (r < 2 + nwc)});
      if ((r >= 2) && (r < 2 + nwc))
        check("weight_in", {24'h0, pe_weight_in}, {24'h0, wmodel[r-2]});
      check("valid", {31'h0, pe_upstream_valid}, {31'h0, in_stream});
      check("done", {31'h0, done}, {31'h0, r == done_r});
      check("busy", {31'h0, busy}, 32'h1);
      check("enable", {31'h0, pe_enable}, {31'h0, r < done_r});
      if (r == 1) begin
        check("act_func_sel", {30'h0, pe_act_func_sel}, {30'h0, af});
        check("dataflow_mode", {30'h0, pe_dataflow_mode}, {30'h0, df});
        check("acts_sent_clr", {27'h0, acts_sent}, 32'h0);
      end
      if (in_stream) begin
        check("act_in", {24'h0, pe_activation_in}, {24'h0, amodel[sent]});
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = ($urandom_range(0, 3) != 0);
          default: begin
            rdy = !((sent == 1) && (stall > 0));
            if (!rdy) stall--;
          end
        endcase
        pe_upstream_ready = rdy;
        if (rdy) begin
          sent++;
          if (sent == nac) end_r = r;
        end
      end else begin
        pe_upstream_ready = 1'($urandom_range(0, 1));
      end
      if (r == poke_r) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'($urandom_range(0, 1));
        wr_addr = 4'd0; wr_data = 8'hA5;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (r == abort_r) begin
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_valid", {31'h0, pe_upstream_valid}, 32'h0);
        check("abort_enable", {31'h0, pe_enable}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_act_in", {24'h0, pe_activation_in}, 32'h0);
        check("abort_weight_in", {24'h0, pe_weight_in}, 32'h0);
        check("abort_acts_sent", {27'h0, acts_sent}, 32'h0);
        check("abort_func", {30'h0, pe_act_func_sel}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_done", {31'h0, done}, 32'h0);
        check("post_abort_busy", {31'h0, busy}, 32'h0);
        return;
      end
      if (r == done_r) begin
        finished = 1;
        break;
      end
      @(negedge clk);
    end
    if (!finished) check("done_timeout", 32'h0, 32'h1);
    @(negedge clk);
    check("idle_busy", {31'h0, busy}, 32'h0);
    check("idle_done", {31'h0, done}, 32'h0);
    check("acts_sent", {27'h0, acts_sent}, nac);
    check("func_hold", {30'h0, pe_act_func_sel}, {30'h0, af});
    check("mode_hold", {30'h0, pe_dataflow_mode}, {30'h0, df});
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    num_weights = '0; num_acts = '0; cfg_act_func = '0; cfg_dataflow = '0;
    start = 1'b0; pe_upstream_ready = 1'b0;
    #12;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_enable", {31'h0, pe_enable}, 32'h0);
    check("rst_valid", {31'h0, pe_upstream_valid}, 32'h0);
    check("rst_act_in", {24'h0, pe_activation_in}, 32'h0);
    check("rst_weight_in", {24'h0, pe_weight_in}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    host_wr(1'b0, 0, 8'd4);
    host_wr(1'b1, 0, 8'd1);
    host_wr(1'b1, 1, 8'd2);
    host_wr(1'b1, 2, 8'd3);
    run(1, 3, 2'd0, 2'd0, 0, -1, -1);
    run(1, 3, 2'd0, 2'd0, 2, -1, -1);

    host_wr(1'b0, 0, 8'd2);
    host_wr(1'b0, 1, 8'd4);
    host_wr(1'b0, 2, 8'd6);
    for (int i = 0; i < 3; i++) host_wr(1'b1, i, 8'd5);
    run(3, 3, 2'd2, 2'd1, 0, -1, -1);
    run(0, 0, 2'd1, 2'd3, 0, -1, -1);

    run(2, 3, 2'd1, 2'd2, 1, 3, -1);
    run(3, 3, 2'd0, 2'd1, 0, -1, -1);

    for (int i = 0; i < DEPTH; i++) begin
      host_wr(1'b0, i, 8'($urandom));
      host_wr(1'b1, i, 8'($urandom));
    end
    run(5, 20, 2'd3, 2'd0, 1, -1, 10);
    run(20, 20, 2'd1, 2'd1, 1, -1, -1);
    for (int k = 0; k < 5; k++)
      run($urandom_range(0, 20), $urandom_range(0, 20), 2'($urandom), 2'($urandom), 1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_operand_feeder.md
Name: pe_operand_feeder

Overview:
- Initiator for the neural_network_pe upstream interface.
- Holds a small weight buffer and a small activation buffer, both written by a host. On start it runs a fixed sequence into one PE: clear accumulator, load weights, stream activations using the upstream valid/ready handshake, then drain. It signals done when the sequence finishes.
- Sits between the host/config logic and the PE in the array tile. It replaces ad-hoc stimulus driving of the PE.

Parameters:
- DATA_WIDTH, 8, activation width.
- WEIGHT_WIDTH, 8, weight width.
- WBUF_DEPTH, 16, weight buffer entries (power of 2).
- ABUF_DEPTH, 16, activation buffer entries (power of 2).
- DRAIN_CYCLES, 6, idle cycles after the last activation is accepted, before done.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- wr_en  in  1  host buffer write strobe.
- wr_sel  in  1  0 = weight buffer, 1 = activation buffer.
- wr_addr  in  $clog2(max(WBUF_DEPTH,ABUF_DEPTH))  buffer index; upper bits ignored for the smaller buffer.
- wr_data  in  max(DATA_WIDTH,WEIGHT_WIDTH)  write data, LSB-aligned.
- num_weights  in  $clog2(WBUF_DEPTH)+1  number of weights to load, sampled at start.
- num_acts  in  $clog2(ABUF_DEPTH)+1  number of activations to stream, sampled at start.
- cfg_act_func  in  2  activation function select, sampled at start.
- cfg_dataflow  in  2  dataflow mode, sampled at start.
- start  in  1  begin sequence.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at sequence end.
- acts_sent  out  $clog2(ABUF_DEPTH)+1  activations accepted in the current or last run.
- pe_enable  out  1  PE enable.
- pe_act_func_sel  out  2  to PE act_func_sel.
- pe_dataflow_mode  out  2  to PE dataflow_mode.
- pe_clear_acc  out  1  to PE clear_acc.
- pe_load_weight  out  1  to PE load_weight.
- pe_weight_in  out  WEIGHT_WIDTH signed  to PE weight_in.
- pe_activation_in  out  DATA_WIDTH signed  to PE activation_in.
- pe_upstream_valid  out  1  to PE upstream_valid.
- pe_upstream_ready  in  1  from PE upstream_ready.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Buffer contents are not reset and are retained. Reset asserted mid-sequence aborts immediately: valid drops, no done pulse.
- All outputs are driven from registers or decoded from state/counter registers. There is no combinational path from any input to any output.
- States: IDLE, CLEAR, LOADW, STREAM, DRAIN, DONE.
- IDLE
  - wr_en writes the selected buffer.
  - On start=1 in cycle T:
    - latch the config inputs;
    - clamp num_weights to WBUF_DEPTH and num_acts to ABUF_DEPTH;
    - clear acts_sent;
    - go to CLEAR in T+1.
- CLEAR: exactly one cycle with pe_clear_acc=1. Next state is LOADW, or STREAM if weight count is 0, or DRAIN if both counts are 0.
- LOADW: one weight per cycle. pe_load_weight=1 and pe_weight_in=wbuf[k] for k=0..N-1, N consecutive cycles. After the last, go to STREAM, or DRAIN if act count is 0. Weight loading ignores pe_upstream_ready.
- STREAM
  - pe_upstream_valid=1 and pe_activation_in=abuf[j].
  - A handshake occurs on a cycle where valid and pe_upstream_ready are both 1. On a handshake, j and acts_sent increment.
  - Without a handshake, valid and data are held stable. Valid never drops before its handshake.
  - After the handshake of the last index, valid=0 in the next cycle and the state goes to DRAIN.
- DRAIN: counts DRAIN_CYCLES cycles, then DONE.
- DONE: done=1 for one cycle, then IDLE. busy=0 in the cycle after DONE.
- pe_enable=1 in CLEAR, LOADW, STREAM and DRAIN; 0 in IDLE and DONE.
- pe_act_func_sel and pe_dataflow_mode hold the latched config until the next start.
- start while busy is ignored.
- wr_en while busy is dropped and buffers are unchanged. This includes a write in the same cycle as an accepted start.
- Writing to an index at or beyond the selected buffer's depth is ignored.
- pe_weight_in and pe_activation_in hold their last value outside LOADW/STREAM. They are 0 after reset.

Test Plan:
- Write wbuf[0]=4 and abuf=1,2,3; set num_weights=1, num_acts=3, ready always 1, then start. Required:
  - clear_acc at T+1;
  - load_weight with weight 4 at T+2;
  - valid with data 1,2,3 on T+3..T+5;
  - done at T+12;
  - acts_sent=3.
- Same setup, with ready low for 4 cycles while data=2 is presented. Required: valid and data=2 held stable throughout; done delayed exactly 4 cycles; no duplicated or skipped activation.
- Write weights 2,4,6 and abuf[0..2]=5; set num_weights=3, cfg_dataflow=1, cfg_act_func=2. Required:
  - three consecutive load_weight pulses carrying 2, 4, 6;
  - pe_dataflow_mode=1 and pe_act_func_sel=2 from T+1.
- Set num_weights=0 and num_acts=0, then start. Required: CLEAR goes directly to DRAIN; done at T+1+1+DRAIN_CYCLES; valid never asserted.
- Pulse start and wr_en again while busy. Required: neither takes effect; buffer readback via a later run is unchanged.
- Assert rst during STREAM, with num_acts=20 clamped to 16. Required: all outputs 0 asynchronously, no done pulse. A subsequent run streams 16 values using the retained buffer contents.
